// File: rtl/board_history_pkg.sv
// board_pkg: shared definitions for the board store.
//   - piece and colour codes
//   - FSM state encoding
//   - init_piece(): starting-position code for a square index
//   - hist_entry_w(): width of one history entry
// History entry layout, MSB first: {from, to, old_from, old_to}.
//   from/to are AW bits wide. old_from/old_to are PIECE_W bits wide.
package board_pkg;

  localparam int EMPTY  = 0;
  localparam int PAWN   = 1;
  localparam int KNIGHT = 2;
  localparam int BISHOP = 3;
  localparam int ROOK   = 4;
  localparam int QUEEN  = 5;
  localparam int KING   = 6;

  // Colour lives in the piece-code MSB.
  localparam int BLACK = 0;
  localparam int WHITE = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_UNDO = 2'd2
  } state_t;

  function automatic int hist_entry_w(int aw, int piece_w);
    return 2 * aw + 2 * piece_w;
  endfunction

  // Back-rank piece for a column. Columns beyond 7 have no pattern.
  function automatic int back_rank(int col);
    int code;
    case (col)
      0, 7:    code = ROOK;
      1, 6:    code = KNIGHT;
      2, 5:    code = BISHOP;
      3:       code = QUEEN;
      4:       code = KING;
      default: code = EMPTY;
    endcase
    return code;
  endfunction

  function automatic int init_piece(int idx, int rows, int cols, int piece_w);
    int row;
    int col;
    int back;
    int colour_bit;
    int code;
    row        = idx / cols;
    col        = idx % cols;
    back       = back_rank(col);
    colour_bit = WHITE << (piece_w - 1);
    code       = EMPTY;
    // An empty back-rank slot marks a column past 7.
    // The whole column, pawns included, stays empty.
    if (back != EMPTY) begin
      if (row == 0)             code = colour_bit | back;
      else if (row == 1)        code = colour_bit | PAWN;
      else if (row == rows - 2) code = PAWN;
      else if (row == rows - 1) code = back;
    end
    return code;
  endfunction

endpackage

// File: rtl/board_history_undo_stack.sv
// undo_stack: circular LIFO holding the most recent DEPTH history entries.
//
// Ports:
//   clk, rst   - clock and synchronous active-high reset (empties the stack)
//   clr        - synchronous clear (empties the stack)
//   push       - store push_data at wr_ptr
//                when full, the oldest entry is overwritten
//   push_data  - entry to store
//   pop        - drop the top entry (ignored when empty)
//   top_data   - entry most recently pushed and not yet popped
//   count      - number of valid entries, saturating at DEPTH
module undo_stack #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] top_data,
  output logic [CW-1:0]    count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    top_ptr;

  // wr_ptr names the next free slot. The top of the stack is the slot behind it.
  always_comb top_ptr = (wr_ptr == '0) ? LAST : wr_ptr - PW'(1);
  assign top_data = mem[top_ptr];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (push) begin
      wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
      // When full, the overwritten slot was the oldest entry.
      // The depth therefore does not change.
      if (count != FULL) count <= count + CW'(1);
    end else if (pop && (count != '0)) begin
      wr_ptr <= top_ptr;
      count  <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/board_history.sv
// board_history: ROWS x COLS board register array with move commit and undo.
//
// Ports:
//   clk, rst    - clock and synchronous active-high reset
//                 reset clears the board and starts INIT
//   init_req    - pulse; reload the start position and clear history
//   mv_valid    - move request
//   mv_ready    - move accepted on a cycle where mv_valid and mv_ready are both high
//   mv_from     - source square; cleared to 0 on commit
//   mv_to       - destination square; receives mv_piece
//   mv_piece    - code written to mv_to
//   undo_req    - pulse; revert the last move (ignored with empty history)
//   undo_ack    - one-cycle pulse when an undo has been applied
//   undo_empty  - history is empty
//   hist_count  - number of stored moves
//   busy        - FSM is in INIT or UNDO
//   board_flat  - square i at bits [i*PIECE_W +: PIECE_W]
//   state_dbg   - current FSM state encoding
//
// Move handshake:
//   mv_ready is high only in IDLE, with neither init_req nor undo_req asserted.
//   A move commits on the clock edge where mv_valid and mv_ready are both high.
//   mv_ready is the only combinational output.
module board_history
  import board_pkg::*;
#(
  parameter  int ROWS       = 8,
  parameter  int COLS       = 8,
  parameter  int PIECE_W    = 4,
  parameter  int UNDO_DEPTH = 16,
  localparam int SQ         = ROWS * COLS,
  localparam int AW         = $clog2(SQ),
  localparam int HW         = $clog2(UNDO_DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    init_req,
  input  logic                    mv_valid,
  output logic                    mv_ready,
  input  logic [AW-1:0]           mv_from,
  input  logic [AW-1:0]           mv_to,
  input  logic [PIECE_W-1:0]      mv_piece,
  input  logic                    undo_req,
  output logic                    undo_ack,
  output logic                    undo_empty,
  output logic [HW-1:0]           hist_count,
  output logic                    busy,
  output logic [SQ*PIECE_W-1:0]   board_flat,
  output logic [1:0]              state_dbg
);

  localparam int EW = hist_entry_w(AW, PIECE_W);
  localparam logic [AW-1:0] LAST_SQ = AW'(SQ - 1);

  state_t               state;
  state_t               next_state;
  logic [AW-1:0]        idx;
  logic [PIECE_W-1:0]   board [SQ];
  logic [PIECE_W-1:0]   init_val;
  logic [EW-1:0]        undo_entry;
  logic [EW-1:0]        top_data;
  logic [EW-1:0]        push_data;
  logic                 mv_accept;
  logic                 undo_start;
  logic                 hist_clr;

  logic [AW-1:0]        u_from;
  logic [AW-1:0]        u_to;
  logic [PIECE_W-1:0]   u_old_from;
  logic [PIECE_W-1:0]   u_old_to;

  assign init_val   = PIECE_W'(init_piece(int'(idx), ROWS, COLS, PIECE_W));
  assign push_data  = {mv_from, mv_to, board[mv_from], board[mv_to]};

  assign u_from     = undo_entry[EW-1 -: AW];
  assign u_to       = undo_entry[EW-1-AW -: AW];
  assign u_old_from = undo_entry[2*PIECE_W-1 -: PIECE_W];
  assign u_old_to   = undo_entry[PIECE_W-1:0];

  undo_stack #(
    .WIDTH (EW),
    .DEPTH (UNDO_DEPTH),
    .CW    (HW)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .clr       (hist_clr),
    .push      (mv_accept),
    .push_data (push_data),
    .pop       (state == ST_UNDO),
    .top_data  (top_data),
    .count     (hist_count)
  );

  // Next state and per-cycle control.
  // Priority in IDLE: init_req, then undo_req, then mv_valid.
  always_comb begin
    next_state = state;
    mv_ready   = 1'b0;
    mv_accept  = 1'b0;
    undo_start = 1'b0;
    hist_clr   = 1'b0;
    case (state)
      ST_IDLE: begin
        mv_ready = !init_req && !undo_req;
        if (init_req) begin
          next_state = ST_INIT;
          hist_clr   = 1'b1;
        end else if (undo_req) begin
          // An undo with empty history is dropped without any effect.
          if (hist_count != '0) begin
            next_state = ST_UNDO;
            undo_start = 1'b1;
          end
        end else if (mv_valid) begin
          mv_accept = 1'b1;
        end
      end
      ST_INIT: begin
        if (idx == LAST_SQ) next_state = ST_IDLE;
      end
      ST_UNDO: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_INIT;
      idx        <= '0;
      undo_ack   <= 1'b0;
      undo_entry <= '0;
      for (int i = 0; i < SQ; i++) board[i] <= '0;
    end else begin
      state    <= next_state;
      undo_ack <= (state == ST_UNDO);
      case (state)
        ST_IDLE: begin
          idx <= '0;
          if (undo_start) undo_entry <= top_data;
          // The later assignment wins.
          // When from == to, the square ends up holding mv_piece.
          if (mv_accept) begin
            board[mv_from] <= '0;
            board[mv_to]   <= mv_piece;
          end
        end
        ST_INIT: begin
          board[idx] <= init_val;
          idx        <= (idx == LAST_SQ) ? '0 : idx + AW'(1);
        end
        ST_UNDO: begin
          // The from-square is restored last, so it wins when from == to.
          board[u_to]   <= u_old_to;
          board[u_from] <= u_old_from;
        end
        default: begin
          idx <= '0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < SQ; g++) begin : g_flat
    assign board_flat[g*PIECE_W +: PIECE_W] = board[g];
  end

  assign busy       = (state != ST_IDLE);
  assign undo_empty = (hist_count == '0);
  assign state_dbg  = state;

endmodule

// File: tb/tb_board_history.sv
// Testbench for board_history.
// The driver tasks update a reference model and queue the expected response.
// The monitor pops and compares whenever the DUT presents an event:
//   - a move commit,
//   - an undo_ack,
//   - the end of INIT.
module tb_board_history;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int PW   = 4;
  localparam int UD   = 16;
  localparam int SQ   = ROWS * COLS;
  localparam int AW   = $clog2(SQ);
  localparam int HW   = $clog2(UD + 1);
  localparam int BW   = SQ * PW;
  localparam int W    = 2 + HW + BW;

  localparam logic [1:0] K_MOVE = 2'd1;
  localparam logic [1:0] K_UNDO = 2'd2;
  localparam logic [1:0] K_INIT = 2'd3;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic          rst;
  logic          init_req;
  logic          mv_valid;
  logic          mv_ready;
  logic [AW-1:0] mv_from;
  logic [AW-1:0] mv_to;
  logic [PW-1:0] mv_piece;
  logic          undo_req;
  logic          undo_ack;
  logic          undo_empty;
  logic [HW-1:0] hist_count;
  logic          busy;
  logic [BW-1:0] board_flat;
  logic [1:0]    state_dbg;

  board_history #(
    .ROWS       (ROWS),
    .COLS       (COLS),
    .PIECE_W    (PW),
    .UNDO_DEPTH (UD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .init_req   (init_req),
    .mv_valid   (mv_valid),
    .mv_ready   (mv_ready),
    .mv_from    (mv_from),
    .mv_to      (mv_to),
    .mv_piece   (mv_piece),
    .undo_req   (undo_req),
    .undo_ack   (undo_ack),
    .undo_empty (undo_empty),
    .hist_count (hist_count),
    .busy       (busy),
    .board_flat (board_flat),
    .state_dbg  (state_dbg)
  );

  // ---------------------------------------------------------------- bookkeeping
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------------------------------------------------------- reference model
  // The board is a flat vector.
  // History is kept as whole-board snapshots, oldest first, at most UD of them.
  logic [BW-1:0] m_board;
  logic [BW-1:0] m_hist[$];
  logic [W-1:0]  exp_q[$];

  // Start position built from the rules:
  //   - back rank R N B Q K B N R,
  //   - pawns on rows 1 and ROWS-2,
  //   - white carries colour bit 8.
  function automatic logic [PW-1:0] spec_square(int i);
    int r;
    int c;
    int rank[8];
    rank = '{4, 2, 3, 5, 6, 3, 2, 4};
    r = i / COLS;
    c = i % COLS;
    if (c >= 8)        return '0;
    if (r == 0)        return PW'(8 + rank[c]);
    if (r == 1)        return PW'(8 + 1);
    if (r == ROWS - 2) return PW'(1);
    if (r == ROWS - 1) return PW'(rank[c]);
    return '0;
  endfunction

  task automatic push_exp(input logic [1:0] kind);
    exp_q.push_back({kind, HW'(m_hist.size()), m_board});
  endtask

  task automatic model_init();
    for (int i = 0; i < SQ; i++) m_board[i*PW +: PW] = spec_square(i);
    m_hist.delete();
    push_exp(K_INIT);
  endtask

  task automatic model_move(input int f, input int t, input int p);
    if (m_hist.size() == UD) void'(m_hist.pop_front());
    m_hist.push_back(m_board);
    m_board[f*PW +: PW] = '0;
    m_board[t*PW +: PW] = PW'(p);
    push_exp(K_MOVE);
  endtask

  function automatic logic [PW-1:0] dut_sq(int i);
    return board_flat[i*PW +: PW];
  endfunction

  // ---------------------------------------------------------------- monitor
  logic acc_pending = 1'b0;
  logic busy_prev   = 1'b0;

  task automatic check_event(input logic [1:0] kind);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      chk("unexpected_event", {{(BW-2){1'b0}}, kind}, '0);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind_hist", {{(BW-2-HW){1'b0}}, kind, hist_count},
          {{(BW-2-HW){1'b0}}, e[W-1 -: 2+HW]});
      chk("event_board", board_flat, e[BW-1:0]);
    end
  endtask

  always @(negedge clk) begin
    if (acc_pending)                         check_event(K_MOVE);
    else if (undo_ack === 1'b1)              check_event(K_UNDO);
    else if (busy_prev && busy === 1'b0)     check_event(K_INIT);
    acc_pending = (mv_valid === 1'b1) && (mv_ready === 1'b1);
    busy_prev   = (busy === 1'b1);
  end

  // ---------------------------------------------------------------- driver tasks
  // All tasks start and end 1 time unit after a rising edge.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) chk("wait_idle_timeout", {{(BW-1){1'b0}}, busy}, '0);
  endtask

  task automatic do_move(input int f, input int t, input int p);
    int n;
    mv_from  = AW'(f);
    mv_to    = AW'(t);
    mv_piece = PW'(p);
    mv_valid = 1'b1;
    model_move(f, t, p);
    n = 0;
    while (mv_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("move_accept_timeout", {{(BW-1){1'b0}}, mv_ready}, 1);
    @(posedge clk); #1;
    mv_valid = 1'b0;
  endtask

  task automatic do_undo();
    logic exp_ack;
    exp_ack = (m_hist.size() > 0);
    if (exp_ack) begin
      m_board = m_hist.pop_back();
      push_exp(K_UNDO);
    end
    undo_req = 1'b1;
    @(posedge clk); #1;
    undo_req = 1'b0;
    chk("undo_ack_e0", {{(BW-1){1'b0}}, undo_ack}, '0);
    @(posedge clk); #1;
    chk("undo_ack_e1", {{(BW-1){1'b0}}, undo_ack}, {{(BW-1){1'b0}}, exp_ack});
    @(posedge clk); #1;
    chk("undo_ack_pulse", {{(BW-1){1'b0}}, undo_ack}, '0);
  endtask

  task automatic check_now(input string name);
    chk({name, "_board"}, board_flat, m_board);
    chk({name, "_hist"}, {{(BW-HW){1'b0}}, hist_count}, BW'(m_hist.size()));
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int n;
    logic [BW-1:0] snap1;

    rst = 1'b1; init_req = 1'b0; mv_valid = 1'b0; undo_req = 1'b0;
    mv_from = '0; mv_to = '0; mv_piece = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_board", board_flat, '0);
    chk("rst_hist", {{(BW-HW){1'b0}}, hist_count}, '0);
    chk("rst_undo_empty", {{(BW-1){1'b0}}, undo_empty}, 1);
    chk("rst_undo_ack", {{(BW-1){1'b0}}, undo_ack}, '0);
    chk("rst_busy", {{(BW-1){1'b0}}, busy}, 1);
    chk("rst_mv_ready", {{(BW-1){1'b0}}, mv_ready}, '0);
    rst = 1'b0;
    model_init();
    wait_idle(n);
    chk("init_cycles", BW'(n), BW'(SQ));
    chk("sq0", BW'(dut_sq(0)), BW'(4'hC));
    chk("sq4", BW'(dut_sq(4)), BW'(4'hE));
    chk("sq12", BW'(dut_sq(12)), BW'(4'h9));
    chk("sq32", BW'(dut_sq(32)), '0);
    chk("sq52", BW'(dut_sq(52)), BW'(4'h1));
    chk("sq63", BW'(dut_sq(63)), BW'(4'h4));

    // Single move, then undo, then undo on empty history
    do_move(12, 28, 9);
    chk("mv_sq12", BW'(dut_sq(12)), '0);
    chk("mv_sq28", BW'(dut_sq(28)), BW'(4'h9));
    chk("mv_hist", {{(BW-HW){1'b0}}, hist_count}, 1);
    chk("mv_undo_empty", {{(BW-1){1'b0}}, undo_empty}, '0);
    do_undo();
    chk("undo_sq12", BW'(dut_sq(12)), BW'(4'h9));
    chk("undo_sq28", BW'(dut_sq(28)), '0);
    do_undo();
    check_now("empty_undo");

    // Capture then undo
    do_move(12, 51, 9);
    do_undo();
    chk("cap_sq51", BW'(dut_sq(51)), BW'(4'h1));
    chk("cap_sq12", BW'(dut_sq(12)), BW'(4'h9));

    // Overflow: 17 back-to-back moves, 16 undos, then one ignored undo
    snap1 = '0;
    for (int i = 0; i < 17; i++) begin
      do_move($urandom_range(0, SQ-1), $urandom_range(0, SQ-1), $urandom_range(0, 15));
      if (i == 0) snap1 = m_board;
    end
    chk("ovf_hist", {{(BW-HW){1'b0}}, hist_count}, BW'(UD));
    for (int i = 0; i < 16; i++) do_undo();
    chk("ovf_board_after_move1", board_flat, snap1);
    do_undo();
    check_now("ovf_extra_undo");

    // Simultaneous init/undo/move with history present
    do_move(1, 18, 4'hA);
    init_req = 1'b1; undo_req = 1'b1; mv_valid = 1'b1; mv_from = 6'd8; mv_to = 6'd16;
    #1;
    chk("simul_mv_ready", {{(BW-1){1'b0}}, mv_ready}, '0);
    model_init();
    @(posedge clk); #1;
    init_req = 1'b0; undo_req = 1'b0; mv_valid = 1'b0;
    chk("simul_hist_cleared", {{(BW-HW){1'b0}}, hist_count}, '0);
    wait_idle(n);
    chk("simul_init_cycles", BW'(n), BW'(SQ));

    // Reset during UNDO
    do_move(6, 21, 4'hA);
    undo_req = 1'b1;
    @(posedge clk); #1;
    undo_req = 1'b0;
    chk("rmu_busy", {{(BW-1){1'b0}}, busy}, 1);
    chk("rmu_mv_ready", {{(BW-1){1'b0}}, mv_ready}, '0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rmu_board_zero", board_flat, '0);
    chk("rmu_undo_ack", {{(BW-1){1'b0}}, undo_ack}, '0);
    chk("rmu_hist", {{(BW-HW){1'b0}}, hist_count}, '0);
    rst = 1'b0;
    model_init();
    wait_idle(n);
    chk("rmu_init_cycles", BW'(n), BW'(SQ));

    // Randomized mix of moves and undos
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) do_undo();
      else do_move($urandom_range(0, SQ-1), $urandom_range(0, SQ-1), $urandom_range(0, 15));
    end
    check_now("random_end");

    repeat (3) @(posedge clk);
    #1;
    chk("exp_q_drained", BW'(exp_q.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #(20000 * 40);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/board_history.md
# board_history

Parametrised board state store with undo history, next generation of the top-level board register array. It holds an R×C grid of piece codes and loads the starting position sequentially after reset or on request. It commits two-square moves atomically through a valid/ready handshake and keeps a circular history of the last UNDO_DEPTH moves for single-step undo. It sits between the game-logic FSM (move/undo source) and the display interface (consumer of `board_flat`).

## Interface
- `ROWS`, 8, board rows; must be ≥ 4.
- `COLS`, 8, board columns; back-rank pattern is defined for columns 0–7 only, higher columns load empty.
- `PIECE_W`, 4, piece code width; must be ≥ 4; MSB = colour (1 = white).
- `UNDO_DEPTH`, 16, number of history entries; must be ≥ 1.
- Derived values: SQ = ROWS·COLS, AW = clog2(SQ), HW = clog2(UNDO_DEPTH+1).

Ports:
- `clk` in 1: single clock, 25 MHz domain.
- `rst` in 1: synchronous, active-high.
- `init_req` in 1: pulse; reloads the start position and clears history.
- `mv_valid` in 1: move request.
- `mv_ready` out 1: move accepted on any cycle where `mv_valid` and `mv_ready` are both high.
- `mv_from` in AW: source square, cleared to 0.
- `mv_to` in AW: destination square.
- `mv_piece` in PIECE_W: code written to `mv_to`; covers promotion.
- `undo_req` in 1: pulse; reverts the last move.
- `undo_ack` out 1: one-cycle pulse when an undo completes.
- `undo_empty` out 1: high when `hist_count` == 0.
- `hist_count` out HW: number of stored moves.
- `busy` out 1: high while in INIT or UNDO.
- `board_flat` out SQ·PIECE_W: square i occupies bits [i·PIECE_W +: PIECE_W]. Square index = row·COLS + col.

## Operation
- States are IDLE, INIT and UNDO.
- **Reset:** on `rst`, clear every board square to 0 and set `hist_count` = 0, wr_ptr = 0 and idx = 0. The FSM enters INIT.
- **INIT:** writes `init_piece(idx)` to square idx once per cycle, for idx = 0…SQ−1. After writing SQ−1 it returns to IDLE. History is cleared on entry. `init_req`, `undo_req` and `mv_valid` are ignored in INIT.
- **Start position**, with codes 0 = empty, 1 = pawn, 2 = knight, 3 = bishop, 4 = rook, 5 = queen, 6 = king:
  - Row 0: white R N B Q K B N R.
  - Row 1: white pawns.
  - Row ROWS−2: black pawns.
  - Row ROWS−1: black back rank.
  - All other rows: 0.
- **IDLE priority:** `init_req` beats `undo_req`, which beats `mv_valid`.
- **mv_ready** = (state == IDLE) & !`init_req` & !`undo_req`.
- **Move commit:** in the accept cycle, write `board[to]` ← `mv_piece` and `board[from]` ← 0. If from == to, the `mv_piece` write wins. Push the entry {from, to, old_from, old_to} at wr_ptr, increment wr_ptr modulo UNDO_DEPTH, and increment `hist_count`, saturating at UNDO_DEPTH.
- **History full:** a new push overwrites the oldest entry (circular buffer) and `hist_count` stays at UNDO_DEPTH.
- **Undo:** in IDLE with `undo_req` and `hist_count` > 0, go to UNDO and register the entry at wr_ptr−1. On the next edge:
  - restore `board[to]` ← old_to, then `board[from]` ← old_from (from write wins);
  - decrement wr_ptr (mod UNDO_DEPTH) and `hist_count`;
  - pulse `undo_ack`;
  - return to IDLE.
- **Undo with empty history:** `undo_req` while `hist_count` == 0 is ignored: no ack, no state change.
- **rst mid-INIT or mid-UNDO:** aborts, clears the board, and restarts INIT.

## Timing
- **Reset values:**
  - `board_flat` = 0, `hist_count` = 0.
  - `undo_empty` = 1, `undo_ack` = 0.
  - `busy` = 1 (state is INIT).
  - `mv_ready` = 0.
- **INIT:** square i becomes visible i+1 cycles after INIT is entered. `busy` falls SQ cycles after the entering edge.
- **Move:** `board_flat` and `hist_count` are updated on the accept edge. The next move can be accepted on the following cycle (throughput 1/cycle).
- **Undo:** accepted at edge E0. The board is restored and `undo_ack` goes high at E1, for the cycle E1→E2. `mv_ready` is 0 during UNDO.
- All outputs are registered except `mv_ready`, which is combinational from state and inputs.

## Structure
- **`board_pkg`** holds:
  - piece and colour codes;
  - the state encoding;
  - the function `init_piece(idx, ROWS, COLS, PIECE_W)`;
  - the history entry layout {from, to, old_from, old_to}.
- **`undo_stack`** sub-module: a circular LIFO of width 2·AW + 2·PIECE_W and depth UNDO_DEPTH. It holds wr_ptr and count and provides push, pop, top-read and saturating-overwrite behaviour.
- The board register array and FSM stay in `board_history`.

## Test plan
- **Reset and start position:** pulse `rst`, wait for `busy` to fall (64 cycles). Require square 0 = 4'hC, 4 = 4'hE, 12 = 4'h9, 32 = 0, 52 = 4'h1, 63 = 4'h4, `hist_count` = 0.
- **Single move:** from = 12, to = 28, piece = 4'h9. Next cycle require square 12 = 0, 28 = 9, `hist_count` = 1, `undo_empty` = 0.
- **Undo after that move:** `undo_req`. Require `undo_ack` exactly 2 edges later, square 12 = 9, 28 = 0, `hist_count` = 0. A further `undo_req` gives no ack and no board change.
- **Capture then undo:** move 12→51 with piece 9. Undo must restore square 51 = 4'h1 and square 12 = 9.
- **Overflow** (UNDO_DEPTH = 16):
  - Apply 17 back-to-back moves; require `hist_count` = 16.
  - Then 16 undos; board must equal the state after move 1.
  - A 17th undo is ignored.
- **Simultaneous requests:**
  - `init_req`, `undo_req` and `mv_valid` in the same cycle: `mv_ready` = 0, INIT runs, history is cleared.
  - `rst` asserted during UNDO: board is zeroed, then reloaded.
